spi_host_byte_merge: RTL and testbench

- Downstream of the SPI host shift register, in the RX path.
- Packs received bytes (byte plus last-of-command flag) into 32-bit words with byte enables for the RX FIFO.
- Terminates a partial word when the last byte of a command arrives, so command boundaries are preserved.
- Holds one accumulation word and one output word register, with a valid/ready handshake on both sides.

---
 rtl/spi_host_byte_merge_if.sv | 37 +++
 rtl/spi_host_byte_merge.sv | 84 ++++++++
 tb/tb_spi_host_byte_merge.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_host_byte_merge_if.sv
// Byte-in / word-out handshake bundle between the SPI host RX shifter and the RX FIFO.
// The master side feeds bytes and takes words; the slave side is the merge block.
interface spi_host_byte_merge_if;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_last_i;
    logic        byte_ready_o;
    logic [31:0] word_o;
    logic [3:0]  word_be_o;
    logic        word_last_o;
    logic        word_valid_o;
    logic        word_ready_i;

    modport master (
        output byte_i,
        output byte_valid_i,
        output byte_last_i,
        input  byte_ready_o,
        input  word_o,
        input  word_be_o,
        input  word_last_o,
        input  word_valid_o,
        output word_ready_i
    );

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        input  byte_last_i,
        output byte_ready_o,
        output word_o,
        output word_be_o,
        output word_last_o,
        output word_valid_o,
        input  word_ready_i
    );
endinterface

// File: rtl/spi_host_byte_merge.sv
// Packs received SPI bytes into 32-bit words with byte enables.
// The last byte of a command closes the word early, so that command boundaries survive into the RX FIFO.
module spi_host_byte_merge #(
    parameter int ByteOrder = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        sw_rst_i,
    spi_host_byte_merge_if.slave        bus
);

    logic [31:0] r_acc;
    logic [3:0]  r_acc_be;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [3:0]  r_word_be;
    logic        r_word_last;
    logic        r_word_valid;

    logic        w_ready;
    logic        w_accept;
    logic        w_complete;
    logic [1:0]  w_lane;
    logic [31:0] w_ins_data;
    logic [3:0]  w_ins_be;

    // A full output register that is not draining back-pressures the byte side.
    assign w_ready    = ~r_word_valid | bus.word_ready_i;
    assign w_accept   = bus.byte_valid_i & w_ready;
    assign w_complete = w_accept & ((r_cnt == 2'd3) | bus.byte_last_i);
    assign w_lane     = (ByteOrder != 0) ? r_cnt : (2'd3 - r_cnt);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_ins_data[8*gi +: 8] = (w_lane == 2'(gi)) ? bus.byte_i : r_acc[8*gi +: 8];
            assign w_ins_be[gi]          = (w_lane == 2'(gi)) | r_acc_be[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc        <= '0;
            r_acc_be     <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_be    <= '0;
            r_word_last  <= 1'b0;
            r_word_valid <= 1'b0;
        end else if (sw_rst_i) begin
            r_acc        <= '0;
            r_acc_be     <= '0;
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_be    <= '0;
            r_word_last  <= 1'b0;
            r_word_valid <= 1'b0;
        end else if (w_complete) begin
            // Reload wins over drain, giving back-to-back words without a bubble.
            r_word       <= w_ins_data;
            r_word_be    <= w_ins_be;
            r_word_last  <= bus.byte_last_i;
            r_word_valid <= 1'b1;
            r_acc        <= '0;
            r_acc_be     <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_accept) begin
                r_acc    <= w_ins_data;
                r_acc_be <= w_ins_be;
                r_cnt    <= r_cnt + 2'd1;
            end
            if (r_word_valid && bus.word_ready_i) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign bus.byte_ready_o = w_ready;
    assign bus.word_o       = r_word;
    assign bus.word_be_o    = r_word_be;
    assign bus.word_last_o  = r_word_last;
    assign bus.word_valid_o = r_word_valid;

endmodule

// File: tb/tb_spi_host_byte_merge.sv
// Directed table-driven bench for spi_host_byte_merge; runs a little-endian and a big-endian instance in lockstep.
module tb_spi_host_byte_merge;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic sw_rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    spi_host_byte_merge_if bus_le ();
    spi_host_byte_merge_if bus_be ();

    spi_host_byte_merge #(.ByteOrder(1)) u_dut_le (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .sw_rst_i (sw_rst_i),
        .bus      (bus_le.slave)
    );

    spi_host_byte_merge #(.ByteOrder(0)) u_dut_be (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .sw_rst_i (sw_rst_i),
        .bus      (bus_be.slave)
    );

    // One record per cycle: inputs for that cycle and the outputs expected during it.
    typedef struct {
        logic [7:0]  b;
        logic        v;
        logic        l;
        logic        wr;
        logic        sr;
        logic        er;
        logic        ev;
        logic [31:0] w_le;
        logic [3:0]  e_le;
        logic [31:0] w_be;
        logic [3:0]  e_be;
        logic        el;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [7:0] b, input logic v, input logic l, input logic wr,
                       input logic sr, input logic er, input logic ev,
                       input logic [31:0] w_le, input logic [3:0] e_le,
                       input logic [31:0] w_be, input logic [3:0] e_be, input logic el);
        vec_t r;
        r.b = b; r.v = v; r.l = l; r.wr = wr; r.sr = sr; r.er = er; r.ev = ev;
        r.w_le = w_le; r.e_le = e_le; r.w_be = w_be; r.e_be = e_be; r.el = el;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic l, input logic wr,
                         input logic sr);
        bus_le.byte_i = b;  bus_le.byte_valid_i = v; bus_le.byte_last_i = l; bus_le.word_ready_i = wr;
        bus_be.byte_i = b;  bus_be.byte_valid_i = v; bus_be.byte_last_i = l; bus_be.word_ready_i = wr;
        sw_rst_i = sr;
    endtask

    // Idle cycle with no expected word.
    task automatic idle(input logic wr, input logic sr, input logic er);
        add(8'h00, 1'b0, 1'b0, wr, sr, er, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0);
    endtask

    // Byte offered, no word expected.
    task automatic byt(input logic [7:0] b, input logic l, input logic wr);
        add(b, 1'b1, l, wr, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        logic        got;
        logic [31:0] hold_le;

        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full word, last on 4th byte
        byt(8'h11, 0, 1); byt(8'h22, 0, 1); byt(8'h33, 0, 1); byt(8'h44, 1, 1);
        add(8'h00, 0, 0, 1, 0, 1, 1, 32'h44332211, 4'hF, 32'h11223344, 4'hF, 1);
        idle(1, 0, 1);
        // Partial words: two bytes, then a single byte
        byt(8'hAA, 0, 1); byt(8'hBB, 1, 1);
        add(8'hCC, 1, 1, 1, 0, 1, 1, 32'h0000BBAA, 4'h3, 32'hAABB0000, 4'hC, 1);
        add(8'h00, 0, 0, 1, 0, 1, 1, 32'h000000CC, 4'h1, 32'hCC000000, 4'h8, 1);
        idle(1, 0, 1);
        // Backpressure: word 1 held, byte side stalls, then drains
        byt(8'h01, 0, 0); byt(8'h02, 0, 0); byt(8'h03, 0, 0); byt(8'h04, 0, 0);
        add(8'h05, 1, 0, 0, 0, 0, 1, 32'h04030201, 4'hF, 32'h01020304, 4'hF, 0);
        add(8'h05, 1, 0, 0, 0, 0, 1, 32'h04030201, 4'hF, 32'h01020304, 4'hF, 0);
        add(8'h05, 1, 0, 1, 0, 1, 1, 32'h04030201, 4'hF, 32'h01020304, 4'hF, 0);
        byt(8'h06, 0, 1); byt(8'h07, 0, 1); byt(8'h08, 1, 1);
        add(8'h00, 0, 0, 1, 0, 1, 1, 32'h08070605, 4'hF, 32'h05060708, 4'hF, 1);
        idle(1, 0, 1);
        // Continuous 12 bytes
        byt(8'h21, 0, 1); byt(8'h22, 0, 1); byt(8'h23, 0, 1); byt(8'h24, 0, 1);
        add(8'h25, 1, 0, 1, 0, 1, 1, 32'h24232221, 4'hF, 32'h21222324, 4'hF, 0);
        byt(8'h26, 0, 1); byt(8'h27, 0, 1); byt(8'h28, 0, 1);
        add(8'h29, 1, 0, 1, 0, 1, 1, 32'h28272625, 4'hF, 32'h25262728, 4'hF, 0);
        byt(8'h2A, 0, 1); byt(8'h2B, 0, 1); byt(8'h2C, 0, 1);
        add(8'h00, 0, 0, 1, 0, 1, 1, 32'h2C2B2A29, 4'hF, 32'h292A2B2C, 4'hF, 0);
        idle(1, 0, 1);
        // Back-to-back single-byte commands: drain and reload in one cycle
        byt(8'h51, 1, 1);
        add(8'h52, 1, 1, 1, 0, 1, 1, 32'h00000051, 4'h1, 32'h51000000, 4'h8, 1);
        add(8'h53, 1, 1, 1, 0, 1, 1, 32'h00000052, 4'h1, 32'h52000000, 4'h8, 1);
        add(8'h00, 0, 0, 1, 0, 1, 1, 32'h00000053, 4'h1, 32'h53000000, 4'h8, 1);
        idle(1, 0, 1);
        // Software reset mid-accumulation, with a byte offered during it
        byt(8'h61, 0, 1); byt(8'h62, 0, 1);
        add(8'h6F, 1, 0, 1, 1, 1, 0, 32'h0, 4'h0, 32'h0, 4'h0, 0);
        byt(8'h71, 0, 1); byt(8'h72, 0, 1); byt(8'h73, 0, 1); byt(8'h74, 0, 1);
        add(8'h00, 0, 0, 1, 0, 1, 1, 32'h74737271, 4'hF, 32'h71727374, 4'hF, 0);
        idle(1, 0, 1);
        // Software reset discards a pending output word
        byt(8'h81, 0, 0); byt(8'h82, 0, 0); byt(8'h83, 0, 0); byt(8'h84, 0, 0);
        add(8'h00, 0, 0, 0, 0, 0, 1, 32'h84838281, 4'hF, 32'h81828384, 4'hF, 0);
        add(8'h00, 0, 0, 0, 1, 0, 1, 32'h84838281, 4'hF, 32'h81828384, 4'hF, 0);
        idle(0, 0, 1);
        byt(8'h91, 0, 1); byt(8'h92, 0, 1); byt(8'h93, 0, 1); byt(8'h94, 0, 1);
        add(8'h00, 0, 0, 1, 0, 1, 1, 32'h94939291, 4'hF, 32'h91929394, 4'hF, 0);
        idle(1, 0, 1);

        // Reset state
        #12;
        chk("rst word_le",  bus_le.word_o,       32'h0);
        chk("rst be_le",    bus_le.word_be_o,    32'h0);
        chk("rst last_le",  bus_le.word_last_o,  32'h0);
        chk("rst valid_le", bus_le.word_valid_o, 32'h0);
        chk("rst word_be",  bus_be.word_o,       32'h0);
        chk("rst valid_be", bus_be.word_valid_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i].b, vecs[i].v, vecs[i].l, vecs[i].wr, vecs[i].sr);
            #1;
            $display("vec %0d: byte=%h v=%b last=%b wr=%b srst=%b -> rdy=%b wvalid=%b word_le=%h be_le=%h word_be=%h",
                     i, vecs[i].b, vecs[i].v, vecs[i].l, vecs[i].wr, vecs[i].sr,
                     bus_le.byte_ready_o, bus_le.word_valid_o, bus_le.word_o, bus_le.word_be_o, bus_be.word_o);
            chk($sformatf("v%0d ready_le", i), bus_le.byte_ready_o, vecs[i].er);
            chk($sformatf("v%0d ready_be", i), bus_be.byte_ready_o, vecs[i].er);
            chk($sformatf("v%0d valid_le", i), bus_le.word_valid_o, vecs[i].ev);
            chk($sformatf("v%0d valid_be", i), bus_be.word_valid_o, vecs[i].ev);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d word_le", i), bus_le.word_o,      vecs[i].w_le);
                chk($sformatf("v%0d be_le", i),   bus_le.word_be_o,   vecs[i].e_le);
                chk($sformatf("v%0d last_le", i), bus_le.word_last_o, vecs[i].el);
                chk($sformatf("v%0d word_be", i), bus_be.word_o,      vecs[i].w_be);
                chk($sformatf("v%0d be_be", i),   bus_be.word_be_o,   vecs[i].e_be);
                chk($sformatf("v%0d last_be", i), bus_be.word_last_o, vecs[i].el);
            end
        end

        // Hand sequence: 3-byte command under backpressure, bounded wait, hold, then release
        @(negedge clk_i); drive(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i); drive(8'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i); drive(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i); drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        got = bus_le.word_valid_o;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk_i); #1;
            got = bus_le.word_valid_o;
        end
        chk("hs valid within budget", 32'(got), 32'h1);
        chk("hs word_le", bus_le.word_o,      32'h00A3A2A1);
        chk("hs be_le",   bus_le.word_be_o,   32'h7);
        chk("hs last_le", bus_le.word_last_o, 32'h1);
        chk("hs word_be", bus_be.word_o,      32'hA1A2A300);
        chk("hs be_be",   bus_be.word_be_o,   32'hE);
        hold_le = 32'h00A3A2A1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk_i); #1;
            chk($sformatf("hs hold%0d valid", n), bus_le.word_valid_o, 32'h1);
            chk($sformatf("hs hold%0d word", n),  bus_le.word_o,       hold_le);
            chk($sformatf("hs hold%0d ready", n), bus_le.byte_ready_o, 32'h0);
        end
        @(negedge clk_i); drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("hs release ready", bus_le.byte_ready_o, 32'h1);
        @(negedge clk_i); #1;
        chk("hs drained valid", bus_le.word_valid_o, 32'h0);
        chk("hs drained valid_be", bus_be.word_valid_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
